// File: rtl/mem_access_unit.sv
// MIPS MEM stage: drives a req/ack data-memory port, aligns stores, extends loads, registers MEM/WB.
// Optional build macro MEM_TIMEOUT_EN adds an ACCESS-state watchdog of TIMEOUT_CYCLES cycles.
module mem_access_unit #(
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [31:0]       i_ex_m_alu_result,
  input  logic [31:0]       i_ex_m_write_data,
  input  logic [4:0]        i_ex_m_rd,
  input  logic              i_ex_m_mem_read,
  input  logic              i_ex_m_mem_write,
  input  logic              i_ex_m_mem_to_reg,
  input  logic              i_ex_m_reg_write,
  input  logic [2:0]        i_ex_m_bhw_type,
  input  logic              i_ex_m_halt,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [3:0]        o_dmem_be,
  output logic [31:0]       o_dmem_wdata,
  input  logic [31:0]       i_dmem_rdata,
  input  logic              i_dmem_ack,
  output logic              o_mem_stall,
  output logic              o_misaligned,
  output logic [31:0]       o_m_wb_read_data,
  output logic [31:0]       o_m_wb_alu_result,
  output logic [4:0]        o_m_wb_rd,
  output logic              o_m_wb_reg_write,
  output logic              o_m_wb_mem_to_reg,
  output logic              o_m_wb_halt
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [31:0]       wdata_q;
  logic [2:0]        bhw_q;
  logic [1:0]        lo_q;
  logic [31:0]       alu_q;
  logic [4:0]        rd_q;
  logic              reg_write_q;
  logic              mem_to_reg_q;
  logic              halt_q;
  logic [31:0]       rdata_q;

  logic        mem_op;
  logic        is_word;
  logic        is_half;
  logic        mis_op;
  logic        start_op;
  logic [3:0]  be_c;
  logic [31:0] wdata_c;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ext_c;
  logic [31:0] load_data;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             timed_out_q;
`endif

  assign mem_op   = i_ex_m_mem_read | i_ex_m_mem_write;
  assign is_word  = i_ex_m_bhw_type[1];
  assign is_half  = (i_ex_m_bhw_type[1:0] == 2'b01);
  assign mis_op   = mem_op && ((is_word && (i_ex_m_alu_result[1:0] != 2'b00)) ||
                               (is_half && i_ex_m_alu_result[0]));
  assign start_op = mem_op && !mis_op;

  // The EX/MEM register is frozen from the IDLE cycle of a memory op until RESP.
  assign o_mem_stall  = !i_reset && (((state == ST_IDLE) && start_op) || (state == ST_ACCESS));
  assign o_dmem_req   = (state == ST_ACCESS);
  assign o_dmem_we    = o_dmem_req && we_q;
  assign o_dmem_addr  = addr_q;
  assign o_dmem_be    = be_q;
  assign o_dmem_wdata = wdata_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    be_c    = 4'b1111;
    wdata_c = i_ex_m_write_data;
    if (is_half) begin
      be_c    = i_ex_m_alu_result[1] ? 4'b1100 : 4'b0011;
      wdata_c = {2{i_ex_m_write_data[15:0]}};
    end else if (!is_word) begin
      be_c    = 4'b0001 << i_ex_m_alu_result[1:0];
      wdata_c = {4{i_ex_m_write_data[7:0]}};
    end
  end

  always_comb begin
    ld_byte = rdata_q[{lo_q, 3'b000} +: 8];
    ld_half = rdata_q[{lo_q[1], 4'b0000} +: 16];
    ext_c   = rdata_q;
    if (!bhw_q[1]) begin
      if (bhw_q[0]) ext_c = {{16{ld_half[15] & ~bhw_q[2]}}, ld_half};
      else          ext_c = {{24{ld_byte[7] & ~bhw_q[2]}}, ld_byte};
    end
  end

`ifdef MEM_TIMEOUT_EN
  assign load_data = timed_out_q ? 32'hDEAD_BEEF : ext_c;
`else
  assign load_data = ext_c;
`endif

  always_ff @(posedge i_clk) begin
    // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
    if (i_reset) begin
      state             <= ST_IDLE;
      addr_q            <= '0;
      we_q              <= 1'b0;
      be_q              <= 4'b0000;
      wdata_q           <= 32'd0;
      bhw_q             <= 3'd0;
      lo_q              <= 2'd0;
      alu_q             <= 32'd0;
      rd_q              <= 5'd0;
      reg_write_q       <= 1'b0;
      mem_to_reg_q      <= 1'b0;
      halt_q            <= 1'b0;
      rdata_q           <= 32'd0;
      o_misaligned      <= 1'b0;
      o_m_wb_read_data  <= 32'd0;
      o_m_wb_alu_result <= 32'd0;
      o_m_wb_rd         <= 5'd0;
      o_m_wb_reg_write  <= 1'b0;
      o_m_wb_mem_to_reg <= 1'b0;
      o_m_wb_halt       <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      tmo_cnt           <= '0;
      timed_out_q       <= 1'b0;
`endif
    end else begin
      o_misaligned <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_op) begin
            addr_q           <= i_ex_m_alu_result[ADDR_W+1:2];
            we_q             <= i_ex_m_mem_write;
            be_q             <= be_c;
            wdata_q          <= wdata_c;
            bhw_q            <= i_ex_m_bhw_type;
            lo_q             <= i_ex_m_alu_result[1:0];
            alu_q            <= i_ex_m_alu_result;
            rd_q             <= i_ex_m_rd;
            reg_write_q      <= i_ex_m_reg_write;
            mem_to_reg_q     <= i_ex_m_mem_to_reg;
            halt_q           <= i_ex_m_halt;
            o_m_wb_reg_write <= 1'b0;
            o_m_wb_halt      <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            tmo_cnt          <= '0;
            timed_out_q      <= 1'b0;
`endif
            state            <= ST_ACCESS;
          end else begin
            // Non-memory ops and misaligned ops retire straight through; the latter write nothing.
            o_m_wb_read_data  <= 32'd0;
            o_m_wb_alu_result <= i_ex_m_alu_result;
            o_m_wb_rd         <= i_ex_m_rd;
            o_m_wb_reg_write  <= i_ex_m_reg_write && !mis_op;
            o_m_wb_mem_to_reg <= i_ex_m_mem_to_reg && !mis_op;
            o_m_wb_halt       <= i_ex_m_halt;
            o_misaligned      <= mis_op;
          end
        end
        ST_ACCESS: begin
          if (i_dmem_ack) begin
            rdata_q <= i_dmem_rdata;
            state   <= ST_RESP;
          end
`ifdef MEM_TIMEOUT_EN
          else if (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            timed_out_q  <= 1'b1;
            o_misaligned <= 1'b1;
            state        <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        ST_RESP: begin
          o_m_wb_read_data  <= we_q ? 32'd0 : load_data;
          o_m_wb_alu_result <= alu_q;
          o_m_wb_rd         <= rd_q;
          o_m_wb_reg_write  <= reg_write_q;
          o_m_wb_mem_to_reg <= mem_to_reg_q;
          o_m_wb_halt       <= halt_q;
          state             <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table plus MEM/WB scoreboard and reset/timeout sequences.
// Build with MEM_TIMEOUT_EN defined to exercise the watchdog; otherwise the indefinite-wait path is checked.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_ex_m_alu_result;
  logic [31:0] i_ex_m_write_data;
  logic [4:0]  i_ex_m_rd;
  logic        i_ex_m_mem_read;
  logic        i_ex_m_mem_write;
  logic        i_ex_m_mem_to_reg;
  logic        i_ex_m_reg_write;
  logic [2:0]  i_ex_m_bhw_type;
  logic        i_ex_m_halt;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [9:0]  o_dmem_addr;
  logic [3:0]  o_dmem_be;
  logic [31:0] o_dmem_wdata;
  logic [31:0] i_dmem_rdata;
  logic        i_dmem_ack;
  logic        o_mem_stall;
  logic        o_misaligned;
  logic [31:0] o_m_wb_read_data;
  logic [31:0] o_m_wb_alu_result;
  logic [4:0]  o_m_wb_rd;
  logic        o_m_wb_reg_write;
  logic        o_m_wb_mem_to_reg;
  logic        o_m_wb_halt;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(10), .TIMEOUT_CYCLES(4)) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_ex_m_alu_result(i_ex_m_alu_result), .i_ex_m_write_data(i_ex_m_write_data),
    .i_ex_m_rd(i_ex_m_rd), .i_ex_m_mem_read(i_ex_m_mem_read), .i_ex_m_mem_write(i_ex_m_mem_write),
    .i_ex_m_mem_to_reg(i_ex_m_mem_to_reg), .i_ex_m_reg_write(i_ex_m_reg_write),
    .i_ex_m_bhw_type(i_ex_m_bhw_type), .i_ex_m_halt(i_ex_m_halt),
    .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
    .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata),
    .i_dmem_rdata(i_dmem_rdata), .i_dmem_ack(i_dmem_ack),
    .o_mem_stall(o_mem_stall), .o_misaligned(o_misaligned),
    .o_m_wb_read_data(o_m_wb_read_data), .o_m_wb_alu_result(o_m_wb_alu_result),
    .o_m_wb_rd(o_m_wb_rd), .o_m_wb_reg_write(o_m_wb_reg_write),
    .o_m_wb_mem_to_reg(o_m_wb_mem_to_reg), .o_m_wb_halt(o_m_wb_halt)
  );

  typedef struct {
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic        rd_op;
    logic        wr_op;
    logic [2:0]  bhw;
    logic        rw;
    logic        m2r;
    logic        halt;
    logic [31:0] mem_word;
    int          wait_n;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_mis;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  rd;
    logic        rw;
    logic        m2r;
    logic        halt;
    logic        mis;
  } wb_t;

  wb_t  exp_q[$];
  vec_t vecs[14];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd,
                              input logic rd_op, input logic wr_op, input logic [2:0] bhw,
                              input logic rw, input logic m2r, input logic halt,
                              input logic [31:0] mem_word, input int wait_n, input logic [3:0] exp_be,
                              input logic [31:0] exp_wdata, input logic [31:0] exp_rdata,
                              input logic exp_mis);
    vec_t v;
    v.alu = alu; v.wd = wd; v.rd = rd; v.rd_op = rd_op; v.wr_op = wr_op; v.bhw = bhw;
    v.rw = rw; v.m2r = m2r; v.halt = halt; v.mem_word = mem_word; v.wait_n = wait_n;
    v.exp_be = exp_be; v.exp_wdata = exp_wdata; v.exp_rdata = exp_rdata; v.exp_mis = exp_mis;
    return v;
  endfunction

  task automatic drive_idle();
    i_ex_m_alu_result = 32'd0; i_ex_m_write_data = 32'd0; i_ex_m_rd = 5'd0;
    i_ex_m_mem_read = 1'b0; i_ex_m_mem_write = 1'b0; i_ex_m_mem_to_reg = 1'b0;
    i_ex_m_reg_write = 1'b0; i_ex_m_bhw_type = 3'd0; i_ex_m_halt = 1'b0;
  endtask

  task automatic drive_vec(input vec_t v);
    i_ex_m_alu_result = v.alu; i_ex_m_write_data = v.wd; i_ex_m_rd = v.rd;
    i_ex_m_mem_read = v.rd_op; i_ex_m_mem_write = v.wr_op; i_ex_m_mem_to_reg = v.m2r;
    i_ex_m_reg_write = v.rw; i_ex_m_bhw_type = v.bhw; i_ex_m_halt = v.halt;
  endtask

  task automatic compare_wb(input string tag);
    wb_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s_sb: got retirement expected empty scoreboard", tag);
      return;
    end
    e = exp_q.pop_front();
    check({tag, "_rdata"}, o_m_wb_read_data, e.rdata);
    check({tag, "_alu"},   o_m_wb_alu_result, e.alu);
    check({tag, "_rd"},    32'(o_m_wb_rd), 32'(e.rd));
    check({tag, "_rw"},    32'(o_m_wb_reg_write), 32'(e.rw));
    check({tag, "_m2r"},   32'(o_m_wb_mem_to_reg), 32'(e.m2r));
    check({tag, "_halt"},  32'(o_m_wb_halt), 32'(e.halt));
    check({tag, "_mis"},   32'(o_misaligned), 32'(e.mis));
  endtask

  // Called at a negedge; returns at the negedge after the op has retired through MEM/WB.
  task automatic run_vec(input string tag, input vec_t v);
    wb_t e;
    int  stalls;
    bit  mem;
    mem = v.rd_op | v.wr_op;
    drive_vec(v);
    e.rdata = v.exp_rdata; e.alu = v.alu; e.rd = v.rd;
    e.rw = v.rw & ~v.exp_mis; e.m2r = v.m2r & ~v.exp_mis; e.halt = v.halt; e.mis = v.exp_mis;
    exp_q.push_back(e);
    #1;
    stalls = 0;
    if (mem && !v.exp_mis) begin
      if (o_mem_stall) stalls++;
      for (int i = 0; i <= v.wait_n; i++) begin
        @(negedge clk);
        check({tag, "_req"},  32'(o_dmem_req), 32'd1);
        check({tag, "_addr"}, 32'(o_dmem_addr), 32'(v.alu[11:2]));
        check({tag, "_be"},   32'(o_dmem_be), 32'(v.exp_be));
        check({tag, "_we"},   32'(o_dmem_we), 32'(v.wr_op));
        if (v.wr_op) check({tag, "_wdata"}, o_dmem_wdata, v.exp_wdata);
        if (i == 0) check({tag, "_wb_rw_hold"}, 32'(o_m_wb_reg_write), 32'd0);
        if (o_mem_stall) stalls++;
        if (i == v.wait_n) begin
          i_dmem_ack = 1'b1;
          i_dmem_rdata = v.mem_word;
        end
      end
      @(negedge clk);
      i_dmem_ack = 1'b0;
      i_dmem_rdata = 32'h5A5A_5A5A;
      check({tag, "_resp_req"},   32'(o_dmem_req), 32'd0);
      check({tag, "_resp_stall"}, 32'(o_mem_stall), 32'd0);
      check({tag, "_stall_cyc"},  32'(stalls), 32'(v.wait_n + 2));
    end else begin
      check({tag, "_nostall"}, 32'(o_mem_stall), 32'd0);
      check({tag, "_noreq"},   32'(o_dmem_req), 32'd0);
    end
    @(negedge clk);
    compare_wb(tag);
  endtask

  initial begin
    int   cyc;
    vec_t v;
    i_reset = 1'b1;
    i_dmem_ack = 1'b0;
    i_dmem_rdata = 32'd0;
    drive_idle();

    //            alu           wd            rd  rd wr bhw     rw m2r h  mem_word      w  be       wdata         rdata         mis
    vecs[0]  = mk(32'h0000_0010, 32'd0,        5'd5,  0, 0, 3'b000, 1, 0, 0, 32'd0,        0, 4'b1111, 32'd0,        32'd0,        0);
    vecs[1]  = mk(32'h0000_0003, 32'd0,        5'd8,  1, 0, 3'b000, 1, 1, 0, 32'h80FF_1234, 0, 4'b1000, 32'd0,        32'hFFFF_FF80, 0);
    vecs[2]  = mk(32'h0000_0003, 32'd0,        5'd8,  1, 0, 3'b100, 1, 1, 0, 32'h80FF_1234, 0, 4'b1000, 32'd0,        32'h0000_0080, 0);
    vecs[3]  = mk(32'h0000_0001, 32'd0,        5'd6,  1, 0, 3'b000, 1, 1, 0, 32'h0000_7F00, 1, 4'b0010, 32'd0,        32'h0000_007F, 0);
    vecs[4]  = mk(32'h0000_0006, 32'd0,        5'd10, 1, 0, 3'b001, 1, 1, 0, 32'h80FF_1234, 1, 4'b1100, 32'd0,        32'hFFFF_80FF, 0);
    vecs[5]  = mk(32'h0000_0004, 32'd0,        5'd11, 1, 0, 3'b101, 1, 1, 0, 32'h80FF_9234, 0, 4'b0011, 32'd0,        32'h0000_9234, 0);
    vecs[6]  = mk(32'h0000_0008, 32'd0,        5'd3,  1, 0, 3'b110, 1, 1, 1, 32'hCAFE_F00D, 2, 4'b1111, 32'd0,        32'hCAFE_F00D, 0);
    vecs[7]  = mk(32'h0000_0006, 32'h1234_ABCD, 5'd0, 0, 1, 3'b001, 0, 0, 0, 32'hFFFF_FFFF, 3, 4'b1100, 32'hABCD_ABCD, 32'd0,        0);
    vecs[8]  = mk(32'h0000_0105, 32'h1122_3344, 5'd0, 0, 1, 3'b000, 0, 0, 0, 32'hFFFF_FFFF, 0, 4'b0010, 32'h4444_4444, 32'd0,        0);
    vecs[9]  = mk(32'h0000_000C, 32'hDEAD_C0DE, 5'd0, 0, 1, 3'b010, 0, 0, 0, 32'hFFFF_FFFF, 1, 4'b1111, 32'hDEAD_C0DE, 32'd0,        0);
    vecs[10] = mk(32'h0000_0002, 32'd0,        5'd9,  1, 0, 3'b010, 1, 1, 0, 32'd0,        0, 4'b1111, 32'd0,        32'd0,        1);
    vecs[11] = mk(32'hFFFF_FFFF, 32'd0,        5'd31, 0, 0, 3'b000, 1, 0, 1, 32'd0,        0, 4'b1111, 32'd0,        32'd0,        0);
    vecs[12] = mk(32'h0000_0005, 32'd0,        5'd4,  1, 0, 3'b001, 1, 1, 0, 32'd0,        0, 4'b1111, 32'd0,        32'd0,        1);
    vecs[13] = mk(32'h0000_1234, 32'd0,        5'd1,  0, 0, 3'b000, 1, 0, 0, 32'd0,        0, 4'b1111, 32'd0,        32'd0,        0);

    repeat (3) @(negedge clk);
    check("rst_req",   32'(o_dmem_req), 32'd0);
    check("rst_stall", 32'(o_mem_stall), 32'd0);
    check("rst_mis",   32'(o_misaligned), 32'd0);
    check("rst_rdata", o_m_wb_read_data, 32'd0);
    check("rst_alu",   o_m_wb_alu_result, 32'd0);
    check("rst_rw",    32'(o_m_wb_reg_write), 32'd0);
    check("rst_halt",  32'(o_m_wb_halt), 32'd0);
    i_reset = 1'b0;

    for (int i = 0; i < 14; i++) run_vec($sformatf("v%0d", i), vecs[i]);

    // Reset while ACCESS is waiting for ack; a late ack must not write back.
    v = mk(32'h0000_0040, 32'd0, 5'd7, 1, 0, 3'b010, 1, 1, 0, 32'h0102_0304, 0, 4'b1111, 32'd0, 32'h0102_0304, 0);
    drive_vec(v);
    @(negedge clk);
    check("mid_req_before", 32'(o_dmem_req), 32'd1);
    i_reset = 1'b1;
    @(negedge clk);
    check("mid_req",   32'(o_dmem_req), 32'd0);
    check("mid_stall", 32'(o_mem_stall), 32'd0);
    check("mid_alu",   o_m_wb_alu_result, 32'd0);
    check("mid_rd",    32'(o_m_wb_rd), 32'd0);
    check("mid_rw",    32'(o_m_wb_reg_write), 32'd0);
    i_reset = 1'b0;
    drive_idle();
    i_dmem_ack = 1'b1;
    i_dmem_rdata = 32'h1234_5678;
    @(negedge clk);
    i_dmem_ack = 1'b0;
    check("late_ack_rw",    32'(o_m_wb_reg_write), 32'd0);
    check("late_ack_rdata", o_m_wb_read_data, 32'd0);
    check("late_ack_req",   32'(o_dmem_req), 32'd0);
    run_vec("recover", v);

    // Access with no ack for longer than the watchdog limit.
    v = mk(32'h0000_0020, 32'd0, 5'd2, 1, 0, 3'b010, 1, 1, 0, 32'h0BAD_F00D, 0, 4'b1111, 32'd0, 32'h0BAD_F00D, 0);
    drive_vec(v);
    cyc = 0;
`ifdef MEM_TIMEOUT_EN
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!o_dmem_req) break;
      cyc++;
    end
    check("tmo_access_cycles", 32'(cyc), 32'd4);
    check("tmo_resp_mis",      32'(o_misaligned), 32'd1);
    check("tmo_resp_stall",    32'(o_mem_stall), 32'd0);
    @(negedge clk);
    check("tmo_rdata",    o_m_wb_read_data, 32'hDEAD_BEEF);
    check("tmo_mis_drop", 32'(o_misaligned), 32'd0);
    check("tmo_rd",       32'(o_m_wb_rd), 32'd2);
`else
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_dmem_req && o_mem_stall) cyc++;
    end
    check("wait_req_held", 32'(cyc), 32'd20);
    i_dmem_ack = 1'b1;
    i_dmem_rdata = v.mem_word;
    @(negedge clk);
    i_dmem_ack = 1'b0;
    check("wait_resp_req", 32'(o_dmem_req), 32'd0);
    @(negedge clk);
    check("wait_rdata", o_m_wb_read_data, 32'h0BAD_F00D);
    check("wait_mis",   32'(o_misaligned), 32'd0);
`endif

    drive_idle();
    @(negedge clk);
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM stage of the MIPS pipeline; the consumer end of the EX/MEM bundle that the EX stage produces.
- Takes ALU result/address, store data, destination rd, control bits and bhw_type.
- Runs byte/halfword/word loads and stores against a data memory port with a req/ack handshake. Stalls the pipeline while an access is pending.
- Aligns store data, extracts and extends load data, and registers the MEM/WB outputs.

Parameters:
ADDR_W, 10, word-address width driven to data memory
TIMEOUT_CYCLES, 16, ACCESS-state watchdog limit (used only with MEM_TIMEOUT_EN)

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_ex_m_alu_result  in  32  ALU result / byte address
i_ex_m_write_data  in  32  store data (forwarded rt)
i_ex_m_rd  in  5  destination register
i_ex_m_mem_read  in  1  load
i_ex_m_mem_write  in  1  store
i_ex_m_mem_to_reg  in  1  WB source select
i_ex_m_reg_write  in  1  register write enable
i_ex_m_bhw_type  in  3  [1:0] 00=B,01=H,1x=W; [2]=1 zero-extend load
i_ex_m_halt  in  1  halt marker
o_dmem_req  out  1  access request
o_dmem_we  out  1  1=store
o_dmem_addr  out  ADDR_W  word address = alu_result[ADDR_W+1:2]
o_dmem_be  out  4  byte enables (little-endian)
o_dmem_wdata  out  32  lane-replicated store data
i_dmem_rdata  in  32  read word, valid with ack
i_dmem_ack  in  1  access complete
o_mem_stall  out  1  freeze PC/IF/ID/EX and EX/MEM register
o_misaligned  out  1  one-cycle pulse on misaligned access
o_m_wb_read_data  out  32  extended load data
o_m_wb_alu_result  out  32  passed ALU result
o_m_wb_rd  out  5
o_m_wb_reg_write  out  1
o_m_wb_mem_to_reg  out  1
o_m_wb_halt  out  1

Behaviour:
- **Reset values:** all outputs 0; state=IDLE.
- **FSM IDLE / ACCESS / RESP.** A memory op is mem_read|mem_write. The two are never both set; if they are, mem_write wins.
- **IDLE, non-memory op:** o_mem_stall=0. MEM/WB register loads the EX/MEM fields at the clock edge; read_data=0.
- **IDLE, aligned memory op:** o_mem_stall=1 (combinational). Latch addr, we, be, wdata, bhw, rd and control into request regs. Next state ACCESS. MEM/WB is not written; its reg_write is held at 0.
- **ACCESS:**
  - o_dmem_req=1. addr, we, be and wdata stay stable until ack. o_mem_stall=1.
  - ack may arrive in the first ACCESS cycle or later.
  - On ack: capture rdata into the extraction reg, go to RESP.
- **RESP:**
  - o_mem_stall=0, so the pipeline advances at this edge. o_dmem_req=0.
  - MEM/WB loads: extended data for loads, 0 for stores; alu_result and control from the request regs. Next state IDLE.
  - No new request is issued in RESP.
- **Minimum memory-op cost:** 3 cycles, 2 of them stalled.
- **Misaligned op:**
  - Halfword with addr[0]=1, or word with addr[1:0]≠0.
  - No request and no stall. o_misaligned pulses for 1 cycle.
  - Op retires through MEM/WB with reg_write=0 and mem_to_reg=0.
- **Store lanes:**
  - SB: wdata={4{d[7:0]}}, be=4'b0001<<addr[1:0].
  - SH: wdata={2{d[15:0]}}, be=addr[1]?4'b1100:4'b0011.
  - SW: wdata=d, be=4'b1111.
- **Load lanes:**
  - B: byte addr[1:0]. H: half addr[1]. W: full word.
  - Sign-extended if bhw[2]=0, zero-extended if bhw[2]=1. W ignores bhw[2].
- **Halt:** propagates to o_m_wb_halt with the op carrying it, along the same path and timing as reg_write.
- **Reset mid-access:** returns to IDLE next edge. req and stall drop, MEM/WB clears, any late ack is ignored.

Optional Feature:
- **MEM_TIMEOUT_EN defined:**
  - Counter clears on entry to ACCESS and increments each cycle without ack.
  - When it reaches TIMEOUT_CYCLES, the access is aborted: go to RESP, load data forced to 32'hDEADBEEF, o_misaligned pulses to act as the bus-error flag.
- **Undefined:** no counter; ACCESS waits indefinitely.

Test Plan:
- **Non-memory op:** ADD result 0x0000_0010, rd=5, reg_write=1 -> next edge o_m_wb_alu_result=0x10, o_m_wb_rd=5; o_mem_stall never high.
- **Signed byte load:** LB addr 0x0000_0003, mem word 0x80FF_1234, ack in first ACCESS cycle -> stall high 2 cycles, o_m_wb_read_data=0xFFFF_FF80. Same with bhw=100 (LBU) -> 0x0000_0080.
- **Halfword store:** SH addr 0x0000_0006, data 0x1234_ABCD -> o_dmem_addr=1, be=1100, wdata=0xABCD_ABCD, we=1; req held stable through 3 wait cycles until ack.
- **Misaligned word:** LW addr 0x0000_0002 -> no req, o_misaligned pulse 1 cycle, o_m_wb_reg_write=0, no stall.
- **Reset mid-access:** i_reset asserted during ACCESS with ack pending -> next cycle req=0, stall=0, all MEM/WB outputs 0; ack one cycle later causes no writeback.
- **Timeout (MEM_TIMEOUT_EN, TIMEOUT_CYCLES=4):** LW with no ack -> abort after 4 ACCESS cycles, read_data=0xDEADBEEF, o_misaligned pulse.
